// File: rtl/xs3_pkg.sv
// Shared constants and helpers for the serial BCD to Excess-3 transmitter.
// Holds the Excess-3 offset, digit geometry and the frame state codes.
package xs3_pkg;

   localparam logic [3:0] XS3_OFFSET     = 4'b0011;
   localparam int         BITS_PER_DIGIT = 4;
   localparam logic [3:0] BCD_MAX        = 4'd9;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_B0   = 3'd1;
   localparam logic [2:0] S_B1   = 3'd2;
   localparam logic [2:0] S_B2   = 3'd3;
   localparam logic [2:0] S_B3   = 3'd4;

   function automatic logic maj(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/bcd_to_xs3_serial_tx_if.sv
// Parallel BCD digit handshake into the serial Excess-3 transmitter.
// The producer drives valid/digit, the transmitter answers with ready.
interface bcd_to_xs3_serial_tx_if;

   logic       In_Valid;
   logic       In_Ready;
   logic [3:0] In_Bcd;

   modport master (
      output In_Valid,
      output In_Bcd,
      input  In_Ready
   );

   modport slave (
      input  In_Valid,
      input  In_Bcd,
      output In_Ready
   );

endinterface

// File: rtl/xs3_digit_fifo.sv
// Small synchronous digit FIFO; count bit separates full from empty.
// Pointers wrap naturally because DEPTH is a power of two.
module xs3_digit_fifo
   import xs3_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [BITS_PER_DIGIT-1:0] din,
   output logic [BITS_PER_DIGIT-1:0] dout,
   output logic                      full,
   output logic                      empty
);

   localparam int AW = $clog2(DEPTH);

   logic [BITS_PER_DIGIT-1:0] mem_q [DEPTH];
   logic [AW-1:0]             wr_q;
   logic [AW-1:0]             rd_q;
   logic [AW:0]               cnt_q;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) begin
            mem_q[wr_q] <= din;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   assign dout  = mem_q[rd_q];
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/bcd_to_xs3_serial_tx.sv
// Bit-serial BCD to Excess-3 transmitter: FIFO-buffered digits are sent
// LSB first on Z, adding 0011 with a one-bit adder and a carry flop.
module bcd_to_xs3_serial_tx
   import xs3_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                          Clk,
   input  logic                          Rst,
   bcd_to_xs3_serial_tx_if.slave         bus,
   output logic                          Z,
   output logic                          Z_Valid,
   output logic                          Z_First,
   output logic                          Err,
   output logic                          Busy
);

   logic       full, empty, acc, legal, push, pop, k;
   logic [3:0] dout;
   logic [2:0] st_q, st_d;
   logic [3:0] sh_q, sh_d;
   logic       c_q, c_d;
   logic       z_q, z_d;
   logic       zv_q, zv_d;
   logic       zf_q, zf_d;
   logic       err_q, err_d;

   assign bus.In_Ready = !full && !Rst;
   assign acc          = bus.In_Valid && bus.In_Ready;
   assign legal        = (bus.In_Bcd <= BCD_MAX);
   assign push         = acc && legal;
   assign pop          = !empty && ((st_q == S_IDLE) || (st_q == S_B3));

   xs3_digit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .Clk   (Clk),
      .Rst   (Rst),
      .push  (push),
      .pop   (pop),
      .din   (bus.In_Bcd),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   // In Bi the next offset bit is K[i+1]; state codes B0..B2 are 1..3.
   assign k = XS3_OFFSET[st_q[1:0]];

   always_comb begin
      st_d  = st_q;
      sh_d  = sh_q;
      c_d   = c_q;
      z_d   = z_q;
      zv_d  = zv_q;
      zf_d  = 1'b0;
      err_d = acc && !legal;
      unique case (1'b1)
         pop: begin
            st_d = S_B0;
            sh_d = dout;
            z_d  = dout[0] ^ XS3_OFFSET[0];
            c_d  = dout[0] & XS3_OFFSET[0];
            zv_d = 1'b1;
            zf_d = 1'b1;
         end
         (st_q == S_B3) && empty: begin
            st_d = S_IDLE;
            z_d  = 1'b0;
            zv_d = 1'b0;
            c_d  = 1'b0;
         end
         (st_q == S_B0) || (st_q == S_B1) || (st_q == S_B2): begin
            st_d = st_q + 3'd1;
            sh_d = sh_q >> 1;
            z_d  = sh_q[1] ^ k ^ c_q;
            c_d  = maj(sh_q[1], k, c_q);
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         st_q  <= S_IDLE;
         sh_q  <= '0;
         c_q   <= 1'b0;
         z_q   <= 1'b0;
         zv_q  <= 1'b0;
         zf_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         sh_q  <= sh_d;
         c_q   <= c_d;
         z_q   <= z_d;
         zv_q  <= zv_d;
         zf_q  <= zf_d;
         err_q <= err_d;
      end
   end

   assign Z       = z_q;
   assign Z_Valid = zv_q;
   assign Z_First = zf_q;
   assign Err     = err_q;
   assign Busy    = !empty || (st_q != S_IDLE);

endmodule

// File: tb/tb_bcd_to_xs3_serial_tx.sv
// Directed and streaming bench for the serial Excess-3 transmitter.
// A bit queue and a digit queue are filled on accept and drained by Z.
module tb_bcd_to_xs3_serial_tx;

   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic z, zv, zf, err, busy;

   int checks = 0;
   int errors = 0;

   bit exp_z_q[$];
   bit exp_f_q[$];
   int dig_q[$];

   bit stream_on = 1'b0;
   bit seen      = 1'b0;
   int gaps      = 0;
   int err_cnt   = 0;
   int zv_cnt    = 0;
   int grp_val   = 0;
   int grp_n     = 0;

   bcd_to_xs3_serial_tx_if bus ();

   bcd_to_xs3_serial_tx #(.DEPTH(DEPTH)) dut (
      .Clk     (clk),
      .Rst     (rst),
      .bus     (bus),
      .Z       (z),
      .Z_Valid (zv),
      .Z_First (zf),
      .Err     (err),
      .Busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Output side: scoreboard pop, loopback decode, gap and pulse counting.
   always @(negedge clk) begin
      if (err) err_cnt++;
      if (stream_on && seen && !zv) gaps++;
      if (zv) begin
         seen = 1'b1;
         zv_cnt++;
         if (exp_z_q.size() == 0) begin
            chk("spurious_zv", zv, 1'b0);
         end else begin
            chk("z_bit", z, exp_z_q.pop_front());
            chk("z_first", zf, exp_f_q.pop_front());
            if (zf) begin
               grp_val = 0;
               grp_n   = 0;
            end
            grp_val = grp_val | (int'(z) << grp_n);
            grp_n++;
            if (grp_n == 4)
               chk("loopback", grp_val - 3,
                   dig_q.size() > 0 ? dig_q.pop_front() : -1);
         end
      end
   end

   task automatic send(input logic [3:0] d, output int w);
      logic       a;
      logic [3:0] e;
      e = d + 4'd3;
      w = 0;
      bus.In_Valid = 1'b1;
      bus.In_Bcd   = d;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk);
         a = bus.In_Ready;
         @(posedge clk);
         #1;
         if (a) begin
            if (d <= 4'd9) begin
               for (int b = 0; b < 4; b++) begin
                  exp_z_q.push_back(e[b]);
                  exp_f_q.push_back(b == 0);
               end
               dig_q.push_back(int'(d));
            end
            bus.In_Valid = 1'b0;
            return;
         end
         w++;
      end
      bus.In_Valid = 1'b0;
      chk("send_timeout", w, 0);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (!busy && !zv) break;
      end
      chk("drain_busy", busy, 1'b0);
   endtask

   initial begin
      int w;
      int e0;
      int v0;
      bus.In_Valid = 1'b0;
      bus.In_Bcd   = 4'd0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_z", z, 1'b0);
      chk("rst_zv", zv, 1'b0);
      chk("rst_zf", zf, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rdy", bus.In_Ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("rdy_idle", bus.In_Ready, 1'b1);

      send(4'd0, w);
      chk("lat_busy", busy, 1'b1);
      chk("lat_zv0", zv, 1'b0);
      @(posedge clk);
      #1;
      chk("lat_zv1", zv, 1'b1);
      chk("lat_zf1", zf, 1'b1);
      chk("lat_z1", z, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("end_zv", zv, 1'b0);
      chk("end_busy", busy, 1'b0);

      send(4'd9, w);
      wait_idle();
      send(4'd5, w);
      wait_idle();

      seen      = 1'b0;
      gaps      = 0;
      stream_on = 1'b1;
      for (int i = 0; i < 10000; i++)
         send(4'($urandom_range(0, 9)), w);
      stream_on = 1'b0;
      chk("stream_gaps", gaps, 0);
      wait_idle();

      e0        = err_cnt;
      seen      = 1'b0;
      gaps      = 0;
      stream_on = 1'b1;
      send(4'd3, w);
      send(4'd12, w);
      chk("err_pulse", err, 1'b1);
      send(4'd7, w);
      chk("err_clear", err, 1'b0);
      repeat (5) @(posedge clk);
      stream_on = 1'b0;
      chk("err_gaps", gaps, 0);
      wait_idle();
      chk("err_count", err_cnt - e0, 1);

      send(4'd1, w);
      send(4'd2, w);
      send(4'd4, w);
      chk("rdy_full", bus.In_Ready, 1'b0);
      send(4'd8, w);
      chk("full_wait", w, 3);
      wait_idle();

      send(4'd4, w);
      send(4'd1, w);
      send(4'd2, w);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_rdy_comb", bus.In_Ready, 1'b0);
      @(posedge clk);
      #1;
      exp_z_q.delete();
      exp_f_q.delete();
      dig_q.delete();
      chk("mid_rst_z", z, 1'b0);
      chk("mid_rst_zv", zv, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_rdy", bus.In_Ready, 1'b0);
      rst = 1'b0;
      v0  = zv_cnt;
      repeat (12) @(posedge clk);
      #1;
      chk("post_rst_bits", zv_cnt - v0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
